// File: rtl/btb_predictor_pkg.sv
// Shared pipeline constants for the fetch-stage branch target buffer:
// direction-counter encodings, the reset counter value, the opcodes the
// decode uses to derive update_is_jump, and the update-action encoding.
package btb_predictor_pkg;

  // 2-bit saturating direction counter encodings. The MSB is the taken
  // prediction.
  typedef enum logic [1:0] {
    STRONG_NT = 2'b00,
    WEAK_NT   = 2'b01,
    WEAK_T    = 2'b10,
    STRONG_T  = 2'b11
  } ctr_t;

  // Counter value an entry holds out of reset.
  localparam ctr_t CTR_RESET = WEAK_NT;

  // Opcodes used by the decode that classifies a resolved instruction.
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  // Action the table takes at the next clock edge. This is exposed
  // internally as upd_action so checkers can bind to it.
  typedef enum logic [1:0] {
    UPD_NONE      = 2'b00,  // no write: disabled, or a missing not-taken branch
    UPD_TRAIN_BR  = 2'b01,  // hit on a conditional branch: step the counter
    UPD_TRAIN_JMP = 2'b10,  // hit on jal/jalr: force strongly taken
    UPD_ALLOC     = 2'b11   // miss on a taken instruction: claim the slot
  } upd_action_t;

  // True for the unconditional jumps that the decode flags as update_is_jump.
  function automatic logic is_jump_opcode(input logic [6:0] opc);
    return (opc == OPC_JAL) || (opc == OPC_JALR);
  endfunction

endpackage

// File: rtl/btb_predictor_sat_counter2.sv
// 2-bit saturating up/down counter with load. This is pure next-value logic;
// the owner keeps the state register. A load takes priority over counting.
// Incrementing at STRONG_T or decrementing at STRONG_NT leaves the value unchanged.
module sat_counter2
  import btb_predictor_pkg::*;
(
  input  logic [1:0] ctr_in,
  input  logic       load_en,
  input  logic [1:0] load_val,
  input  logic       up,
  input  logic       down,
  output logic [1:0] ctr_out
);

  // Select the load value, otherwise step toward the requested bound.
  always_comb begin
    ctr_out = ctr_in;
    if (load_en) begin
      ctr_out = load_val;
    end else if (up && !down) begin
      if (ctr_in != STRONG_T) ctr_out = ctr_in + 2'b01;
    end else if (down && !up) begin
      if (ctr_in != STRONG_NT) ctr_out = ctr_in - 2'b01;
    end
  end

endmodule

// File: rtl/btb_predictor.sv
// Direct-mapped, register-based branch target buffer with 2-bit direction
// counters. The lookup is combinational from the registered table. Training
// comes from the execute-stage resolver and lands on the next clock edge.
// There is no write-through bypass: a same-cycle lookup sees the old contents.
module btb_predictor
  import btb_predictor_pkg::*;
#(
  parameter int ENTRIES    = 16,
  parameter int INDEX_BITS = $clog2(ENTRIES)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] fetch_pc,
  output logic        pred_valid,
  output logic [31:0] predicted_pc,
  output logic        predicted_taken,
  input  logic        update_en,
  input  logic [31:0] update_src_pc,
  input  logic [31:0] update_target,
  input  logic        update_taken,
  input  logic        update_is_jump,
  input  logic        invalidate_all
);

  localparam int TAG_BITS = 30 - INDEX_BITS;

  // Table storage. Each field is kept in its own array so that resetting and
  // flushing the valid bits touches only the valid array.
  logic                  tbl_valid   [ENTRIES];
  logic [TAG_BITS-1:0]   tbl_tag     [ENTRIES];
  logic [31:0]           tbl_target  [ENTRIES];
  logic [1:0]            tbl_ctr     [ENTRIES];
  logic                  tbl_is_jump [ENTRIES];

  // Lookup-side address split.
  logic [INDEX_BITS-1:0] lk_idx;
  logic [TAG_BITS-1:0]   lk_tag;
  logic                  lk_hit;

  // Update-side address split and decision.
  logic [INDEX_BITS-1:0] upd_idx;
  logic [TAG_BITS-1:0]   upd_tag;
  logic                  upd_hit;
  upd_action_t           upd_action;
  logic                  upd_we;
  logic                  upd_target_we;
  logic                  ctr_load;
  logic [1:0]            ctr_load_val;
  logic                  ctr_up;
  logic                  ctr_down;
  logic [1:0]            ctr_next;

  // The byte offset within a word plays no part in indexing or tagging.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{fetch_pc[1:0], update_src_pc[1:0]};

  assign lk_idx  = fetch_pc[INDEX_BITS+1:2];
  assign lk_tag  = fetch_pc[31:INDEX_BITS+2];
  assign upd_idx = update_src_pc[INDEX_BITS+1:2];
  assign upd_tag = update_src_pc[31:INDEX_BITS+2];

  // Zero-latency lookup. A hit returns the stored target even when the
  // prediction is not-taken. Jumps always predict taken.
  always_comb begin
    lk_hit          = tbl_valid[lk_idx] && (tbl_tag[lk_idx] == lk_tag);
    pred_valid      = 1'b0;
    predicted_pc    = 32'h0;
    predicted_taken = 1'b0;
    if (lk_hit) begin
      pred_valid      = 1'b1;
      predicted_pc    = tbl_target[lk_idx];
      predicted_taken = tbl_ctr[lk_idx][1] | tbl_is_jump[lk_idx];
    end
  end

  // Classify the resolver's update. Every update_* input is gated by
  // update_en, so these inputs are don't-care while update_en is low.
  always_comb begin
    upd_hit    = tbl_valid[upd_idx] && (tbl_tag[upd_idx] == upd_tag);
    upd_action = UPD_NONE;
    if (update_en) begin
      if (upd_hit) begin
        upd_action = update_is_jump ? UPD_TRAIN_JMP : UPD_TRAIN_BR;
      end else if (update_taken) begin
        upd_action = UPD_ALLOC;
      end
    end
  end

  // Derive the write enables and the counter controls from the action.
  always_comb begin
    upd_we        = 1'b0;
    upd_target_we = 1'b0;
    ctr_load      = 1'b0;
    ctr_load_val  = STRONG_T;
    ctr_up        = 1'b0;
    ctr_down      = 1'b0;
    case (upd_action)
      UPD_TRAIN_BR: begin
        upd_we        = 1'b1;
        upd_target_we = update_taken;
        ctr_up        = update_taken;
        ctr_down      = !update_taken;
      end
      UPD_TRAIN_JMP: begin
        upd_we        = 1'b1;
        upd_target_we = 1'b1;
        ctr_load      = 1'b1;
        ctr_load_val  = STRONG_T;
      end
      UPD_ALLOC: begin
        upd_we        = 1'b1;
        upd_target_we = 1'b1;
        ctr_load      = 1'b1;
        ctr_load_val  = update_is_jump ? STRONG_T : WEAK_T;
      end
      default: begin
        upd_we = 1'b0;
      end
    endcase
  end

  // One shared counter datapath on the update path. It works on the addressed
  // entry only.
  sat_counter2 u_ctr (
    .ctr_in   (tbl_ctr[upd_idx]),
    .load_en  (ctr_load),
    .load_val (ctr_load_val),
    .up       (ctr_up),
    .down     (ctr_down),
    .ctr_out  (ctr_next)
  );

  // Table state. A flush clears the valid bits and takes priority over a
  // same-cycle update, which is dropped. The other fields keep their values
  // during a flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        tbl_valid[i]   <= 1'b0;
        tbl_tag[i]     <= '0;
        tbl_target[i]  <= 32'h0;
        tbl_ctr[i]     <= CTR_RESET;
        tbl_is_jump[i] <= 1'b0;
      end
    end else if (invalidate_all) begin
      for (int i = 0; i < ENTRIES; i++) begin
        tbl_valid[i] <= 1'b0;
      end
    end else if (upd_we) begin
      tbl_valid[upd_idx]   <= 1'b1;
      tbl_tag[upd_idx]     <= upd_tag;
      tbl_ctr[upd_idx]     <= ctr_next;
      tbl_is_jump[upd_idx] <= update_is_jump;
      if (upd_target_we) begin
        tbl_target[upd_idx] <= update_target;
      end
    end
  end

endmodule

// File: tb/tb_btb_predictor.sv
// Bench for btb_predictor. Directed steps come first, then randomized
// traffic. Both are checked against a behavioural table model.
module tb_btb_predictor;

  localparam int ENTRIES = 16;
  localparam int IB      = 4;

  logic        clk;
  logic        rst_n;
  logic [31:0] fetch_pc;
  logic        pred_valid;
  logic [31:0] predicted_pc;
  logic        predicted_taken;
  logic        update_en;
  logic [31:0] update_src_pc;
  logic [31:0] update_target;
  logic        update_taken;
  logic        update_is_jump;
  logic        invalidate_all;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: one slot per index, counter kept as a plain integer 0..3.
  bit          m_valid [ENTRIES];
  int unsigned m_tag   [ENTRIES];
  logic [31:0] m_tgt   [ENTRIES];
  int          m_ctr   [ENTRIES];
  bit          m_jmp   [ENTRIES];

  btb_predictor #(.ENTRIES(ENTRIES)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .fetch_pc        (fetch_pc),
    .pred_valid      (pred_valid),
    .predicted_pc    (predicted_pc),
    .predicted_taken (predicted_taken),
    .update_en       (update_en),
    .update_src_pc   (update_src_pc),
    .update_target   (update_target),
    .update_taken    (update_taken),
    .update_is_jump  (update_is_jump),
    .invalidate_all  (invalidate_all)
  );

  // Clock generation.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int m_idx(input logic [31:0] pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction

  function automatic int unsigned m_tagof(input logic [31:0] pc);
    return pc >> (2 + IB);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 32'h0; m_ctr[i] = 1; m_jmp[i] = 0;
    end
  endtask

  task automatic model_update(input bit en, input logic [31:0] src, input logic [31:0] tgt,
                              input bit tk, input bit ij, input bit inv);
    int  i;
    bit  hit;
    i   = m_idx(src);
    hit = m_valid[i] && (m_tag[i] == m_tagof(src));
    if (inv) begin
      for (int k = 0; k < ENTRIES; k++) m_valid[k] = 0;
    end else if (en) begin
      if (hit && ij) begin
        m_ctr[i] = 3; m_tgt[i] = tgt; m_jmp[i] = 1;
      end else if (hit) begin
        if (tk) begin
          m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
          m_tgt[i] = tgt;
        end else begin
          m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
        end
        m_jmp[i] = 0;
      end else if (tk) begin
        m_valid[i] = 1; m_tag[i] = m_tagof(src); m_tgt[i] = tgt;
        m_ctr[i] = ij ? 3 : 2; m_jmp[i] = ij;
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  // Compare the DUT's lookup outputs with the model's prediction for fetch_pc.
  task automatic check_model(input string name);
    int  i;
    bit  hit;
    i   = m_idx(fetch_pc);
    hit = rst_n && m_valid[i] && (m_tag[i] == m_tagof(fetch_pc));
    chk({name, ".pred_valid"}, {31'h0, pred_valid}, {31'h0, hit});
    chk({name, ".predicted_pc"}, predicted_pc, hit ? m_tgt[i] : 32'h0);
    chk({name, ".predicted_taken"}, {31'h0, predicted_taken},
        {31'h0, hit && (m_ctr[i] >= 2 || m_jmp[i])});
  endtask

  // One cycle: drive at negedge, check lookup 1ns later, then apply the edge.
  task automatic step(input string name, input logic [31:0] fpc, input bit en,
                      input logic [31:0] src, input logic [31:0] tgt,
                      input bit tk, input bit ij, input bit inv);
    @(negedge clk);
    fetch_pc = fpc; update_en = en; update_src_pc = src; update_target = tgt;
    update_taken = tk; update_is_jump = ij; invalidate_all = inv;
    #1 check_model(name);
    @(posedge clk);
    if (rst_n) model_update(en, src, tgt, tk, ij, inv);
  endtask

  // Idle lookup with literal expectations in addition to the model check.
  task automatic look(input string name, input logic [31:0] fpc,
                      input bit e_pv, input logic [31:0] e_pc, input bit e_tk);
    @(negedge clk);
    fetch_pc = fpc; update_en = 1'b0; invalidate_all = 1'b0;
    #1;
    chk({name, ".lit_valid"}, {31'h0, pred_valid}, {31'h0, e_pv});
    chk({name, ".lit_pc"}, predicted_pc, e_pc);
    chk({name, ".lit_taken"}, {31'h0, predicted_taken}, {31'h0, e_tk});
    check_model(name);
    @(posedge clk);
  endtask

  task automatic upd(input logic [31:0] src, input logic [31:0] tgt, input bit tk, input bit ij);
    step("upd", src, 1'b1, src, tgt, tk, ij, 1'b0);
  endtask

  // Directed steps, then randomized traffic.
  initial begin
    rst_n = 1'b0; fetch_pc = 32'h100; update_en = 1'b0; update_src_pc = 32'h0;
    update_target = 32'h0; update_taken = 1'b0; update_is_jump = 1'b0; invalidate_all = 1'b0;
    model_reset();
    #1;
    chk("in_reset.pred_valid", {31'h0, pred_valid}, 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    look("post_reset", 32'h100, 1'b0, 32'h0, 1'b0);

    // A taken branch allocates at WEAK_T. The lookup in the same cycle still misses.
    step("alloc_same_cycle", 32'h100, 1'b1, 32'h100, 32'h140, 1'b1, 1'b0, 1'b0);
    look("alloc_hit", 32'h100, 1'b1, 32'h140, 1'b1);

    // One not-taken update moves the counter to WEAK_NT and keeps the target.
    upd(32'h100, 32'h999, 1'b0, 1'b0);
    look("nt_train", 32'h100, 1'b1, 32'h140, 1'b0);

    // A not-taken branch at an address with no entry does not allocate.
    upd(32'h200, 32'h240, 1'b0, 1'b0);
    look("nt_no_alloc", 32'h200, 1'b0, 32'h0, 1'b0);
    look("nt_no_alloc_orig", 32'h100, 1'b1, 32'h140, 1'b0);

    // Repeated taken updates saturate the counter at STRONG_T.
    repeat (4) upd(32'h100, 32'h140, 1'b1, 1'b0);
    look("sat_taken", 32'h100, 1'b1, 32'h140, 1'b1);
    // After saturation, two not-taken updates reach WEAK_NT (0b01).
    upd(32'h100, 32'h140, 1'b0, 1'b0);
    look("sat_down1", 32'h100, 1'b1, 32'h140, 1'b1);
    upd(32'h100, 32'h140, 1'b0, 1'b0);
    look("sat_down2", 32'h100, 1'b1, 32'h140, 1'b0);

    // jalr allocation, then retarget.
    upd(32'h300, 32'h1000, 1'b1, 1'b1);
    look("jalr_hit", 32'h300, 1'b1, 32'h1000, 1'b1);
    upd(32'h300, 32'h2000, 1'b1, 1'b1);
    look("jalr_retarget", 32'h300, 1'b1, 32'h2000, 1'b1);

    // Aliases at index 0: the last taken writer wins.
    upd(32'h100, 32'h140, 1'b1, 1'b0);
    upd(32'h500, 32'h540, 1'b1, 1'b0);
    look("alias_old", 32'h100, 1'b0, 32'h0, 1'b0);
    look("alias_new", 32'h500, 1'b1, 32'h540, 1'b1);

    // A lookup and an update at the same index in one cycle: the lookup sees the old contents.
    step("same_edge_old", 32'h500, 1'b1, 32'h500, 32'h777, 1'b1, 1'b0, 1'b0);
    look("same_edge_new", 32'h500, 1'b1, 32'h777, 1'b1);

    // A flush wins over a same-cycle update.
    upd(32'h104, 32'h1104, 1'b1, 1'b0);
    step("flush", 32'h0, 1'b1, 32'h108, 32'h1108, 1'b1, 1'b0, 1'b1);
    look("flush_a", 32'h500, 1'b0, 32'h0, 1'b0);
    look("flush_b", 32'h104, 1'b0, 32'h0, 1'b0);
    look("flush_c", 32'h108, 1'b0, 32'h0, 1'b0);

    // An asynchronous reset in the middle of an update discards that update.
    upd(32'h10c, 32'h2000, 1'b1, 1'b0);
    @(negedge clk);
    fetch_pc = 32'h10c; update_en = 1'b1; update_src_pc = 32'h110;
    update_target = 32'h3000; update_taken = 1'b1; update_is_jump = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_rst.pred_valid", {31'h0, pred_valid}, 32'h0);
    chk("async_rst.predicted_pc", predicted_pc, 32'h0);
    chk("async_rst.predicted_taken", {31'h0, predicted_taken}, 32'h0);
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1; update_en = 1'b0;
    look("rst_dropped", 32'h110, 1'b0, 32'h0, 1'b0);
    look("rst_cleared", 32'h10c, 1'b0, 32'h0, 1'b0);

    // Random traffic over 4 tags x 16 indices, with rare flushes. The update
    // fields are randomized even while update_en is low.
    for (int n = 0; n < 1500; n++) begin
      logic [31:0] f, s, t;
      bit en, tk, ij, inv;
      f   = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
      s   = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
      t   = $urandom;
      en  = ($urandom_range(0, 9) < 6);
      ij  = ($urandom_range(0, 3) == 0);
      tk  = ij ? 1'b1 : 1'($urandom_range(0, 1));
      inv = ($urandom_range(0, 99) == 0);
      step("rand", f, en, s, t, tk, ij, inv);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/btb_predictor.md
Name: btb_predictor

Overview:
- Fetch-stage branch target buffer with 2-bit saturating direction counters.
- Each cycle it looks up the fetch PC and drives pred_valid, predicted_pc and predicted_taken into the pipeline. The execute-stage branch resolver checks these values.
- It takes the resolver's update_btb, resolved target, actual outcome and instruction class back, and trains the table on the next clock edge.
- Direct-mapped, register-based storage.

Parameters:
- ENTRIES, 16: number of table entries; power of two, at least 2.
- INDEX_BITS, $clog2(ENTRIES): index width. Derived; not to be overridden.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- fetch_pc  in  32  PC being fetched this cycle.
- pred_valid  out  1  fetch_pc hit a valid entry with matching tag.
- predicted_pc  out  32  stored target of the hit entry; 0 on miss.
- predicted_taken  out  1  counter MSB of the hit entry; 0 on miss.
- update_en  in  1  resolver's update_btb (branch or jump retiring from execute).
- update_src_pc  in  32  PC of the resolved instruction.
- update_target  in  32  resolver's jump_addr.
- update_taken  in  1  actual outcome; the resolver drives 1 for jal/jalr.
- update_is_jump  in  1  instruction is jal/jalr.
- invalidate_all  in  1  synchronous flush of every valid bit (fence.i / context switch).

Behaviour:
- **Address split:** index = pc[INDEX_BITS+1:2]; tag = pc[31:INDEX_BITS+2]. pc[1:0] is ignored.
- **Entry fields:** valid, tag, target[31:0], ctr[1:0], is_jump.
- **Reset (async, rst_n low):**
  - all valid = 0, ctr = 2'b01, target = 0, tag = 0, is_jump = 0.
  - Outputs therefore read pred_valid = 0, predicted_pc = 0, predicted_taken = 0 while reset is asserted.
  - Reset mid-update discards that update.
- **Lookup:** purely combinational from the registered table, zero latency.
  - hit = valid[idx] && tag[idx] == fetch tag.
  - On hit: pred_valid = 1; predicted_pc = target[idx], always the stored target, even when predicted not-taken; predicted_taken = ctr[idx][1], forced to 1 if is_jump[idx].
  - On miss: all three outputs are 0.
  - Fetch selects predicted_pc only when pred_valid && predicted_taken; otherwise it uses pc+4.
- **Update (rising edge, update_en = 1, evaluated on update_src_pc):**
  - *Hit, branch:* ctr saturating increment if taken, saturating decrement if not taken (bounds 00 and 11). If taken, target <= update_target. is_jump <= update_is_jump.
  - *Hit, jump:* ctr <= 11; target <= update_target; is_jump <= 1.
  - *Miss (invalid or tag mismatch), taken:* allocate; overwrites any existing entry at that index. valid <= 1, tag, target <= update_target. ctr <= 11 for jump, 10 for branch. is_jump set.
  - *Miss, not taken:* no change; not-taken branches are never allocated.
- **update_en = 0:** table holds.
- **invalidate_all:** on the edge, all valid <= 0; other fields are kept.
  - invalidate_all has priority over a same-cycle update, which is dropped.
- **Simultaneous lookup and update on the same index:** lookup returns the pre-edge contents. There is no write-through bypass; the new contents are visible from the next cycle.
- **Wrap-around:** counters saturate and never wrap. Aliased PCs with the same index but a different tag evict each other (last-taken-writer wins).
- **X-safety:** when update_en = 0, update_* values are don't-care and must not affect state.

Decomposition:
- Shared package (pipeline package):
  - BTB counter encodings: STRONG_NT = 2'b00, WEAK_NT = 2'b01, WEAK_T = 2'b10, STRONG_T = 2'b11.
  - Reset counter value WEAK_NT.
  - Opcode constants OPC_JAL = 7'b1101111, OPC_JALR = 7'b1100111, OPC_BRANCH = 7'b1100011, used by the decode that derives update_is_jump.
- One natural sub-module: sat_counter2, a 2-bit saturating up/down counter with load. It is instantiated per entry or once on the update path.

Test Plan:
- Post-reset lookup:
  - Stimulus: rst_n low then high, fetch_pc = 0x00000100.
  - Required: pred_valid = 0, predicted_pc = 0, predicted_taken = 0.
- Taken-branch allocation and hit:
  - Stimulus: update_en, src 0x00000100, target 0x00000140, taken = 1, is_jump = 0; next cycle fetch 0x00000100.
  - Required: pred_valid = 1, predicted_pc = 0x00000140, predicted_taken = 1 (ctr = 10).
- Not-taken training and no allocation:
  - Stimulus: on the entry above, one not-taken update.
  - Required: ctr = 01, predicted_taken = 0, predicted_pc still 0x00000140.
  - Stimulus: not-taken update at unused src 0x00000200.
  - Required: fetch 0x00000200 still misses.
- Saturation and jump:
  - Stimulus: 4 taken updates on 0x00000100.
  - Required: ctr stays 11.
  - Stimulus: jalr update src 0x00000300, target 0x00001000.
  - Required: hit with predicted_taken = 1.
  - Stimulus: re-update with target 0x00002000.
  - Required: predicted_pc = 0x00002000.
- Alias eviction:
  - ENTRIES = 16 gives index bits [5:2].
  - Stimulus: taken update at 0x00000100, then taken update at 0x00000500 (same index 0, different tag).
  - Required: fetch 0x00000100 misses; fetch 0x00000500 hits.
- Same-edge conflicts:
  - Stimulus: fetch_pc = 0x00000100 while an update writes index 0 in the same cycle.
  - Required: output shows old contents that cycle, new contents the next.
  - Stimulus: invalidate_all together with update_en.
  - Required: afterwards all lookups miss.
  - Stimulus: rst_n asserted mid-sequence.
  - Required: outputs immediately 0.
